// File: rtl/mmio_controller.sv
// Memory-mapped I/O front end for the processor data port: splits the address space
// between data RAM and board I/O (switches, LEDs, PS/2 key FIFO, audio tone register).
module mmio_controller #(
    parameter int IO_BASE   = 4096,
    parameter int KEY_DEPTH = 8,
    parameter int TONE_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       address_dmem,
    input  logic [31:0]       data,
    input  logic              wren,
    output logic [31:0]       q_dmem,
    output logic              ram_wEn,
    output logic [11:0]       ram_addr,
    output logic [31:0]       ram_dataIn,
    input  logic [31:0]       ram_dataOut,
    input  logic [15:0]       SW,
    input  logic [7:0]        key_code,
    input  logic              key_valid,
    output logic [15:0]       LED,
    output logic [TONE_W-1:0] tone,
    output logic              key_irq
);

    localparam int PTR_W = $clog2(KEY_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [31:0] IO_BASE_ADDR = 32'(IO_BASE);
    localparam logic [31:0] OFF_SW       = 32'd0;
    localparam logic [31:0] OFF_LED      = 32'd1;
    localparam logic [31:0] OFF_STAT     = 32'd2;
    localparam logic [31:0] OFF_DATA     = 32'd3;
    localparam logic [31:0] OFF_TONE     = 32'd4;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(KEY_DEPTH);

    typedef enum logic {
        SEL_RAM = 1'b0,
        SEL_IO  = 1'b1
    } sel_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        is_ram;
    logic [31:0] io_off;
    logic        hit_sw;
    logic        hit_led;
    logic        hit_stat;
    logic        hit_data;
    logic        hit_tone;

    assign is_ram   = (address_dmem < IO_BASE_ADDR);
    assign io_off   = address_dmem - IO_BASE_ADDR;
    assign hit_sw   = !is_ram && (io_off == OFF_SW);
    assign hit_led  = !is_ram && (io_off == OFF_LED);
    assign hit_stat = !is_ram && (io_off == OFF_STAT);
    assign hit_data = !is_ram && (io_off == OFF_DATA);
    assign hit_tone = !is_ram && (io_off == OFF_TONE);

    assign ram_wEn    = wren && is_ram;
    assign ram_addr   = address_dmem[11:0];
    assign ram_dataIn = data;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]       sw_meta_reg;
    logic [15:0]       sw_sync_reg;
    logic [15:0]       led_reg;
    logic [TONE_W-1:0] tone_reg;
    logic              key_irq_reg;
    sel_t              sel_q_reg;
    logic [31:0]       io_rdata_reg;

    logic [7:0]        key_mem [KEY_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;

    // ------------------------------------------------------------------
    // Scan-code FIFO control
    // ------------------------------------------------------------------
    logic             fifo_empty;
    logic             fifo_full;
    logic             do_pop;
    logic             do_push;
    logic             key_dropped;
    logic             stat_rd;
    logic [CNT_W-1:0] count_next;
    logic             overflow_next;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_COUNT);
    assign stat_rd    = hit_stat && !wren;

    // A pop frees a slot in the same cycle, so a push into a full FIFO survives it.
    assign do_pop      = hit_data && !wren && !fifo_empty;
    assign do_push     = key_valid && (!fifo_full || do_pop);
    assign key_dropped = key_valid && fifo_full && !do_pop;

    assign count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);

    // A drop in the same cycle as a status read wins over the read-clear.
    always_comb begin
        overflow_next = overflow_reg;
        if (key_dropped) begin
            overflow_next = 1'b1;
        end else if (stat_rd) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            key_mem[wr_ptr_reg] <= key_code;
        end
    end

    // ------------------------------------------------------------------
    // I/O read word, captured on the same edge that registers sel_q
    // ------------------------------------------------------------------
    logic [3:0]  stat_count;
    logic [31:0] stat_word;
    logic [31:0] io_word;

    assign stat_count = 4'(count_reg);
    assign stat_word  = {24'd0, stat_count, 2'b00, overflow_reg, !fifo_empty};

    always_comb begin
        io_word = 32'd0;
        if (hit_sw) begin
            io_word = {16'd0, sw_sync_reg};
        end else if (hit_led) begin
            io_word = {16'd0, led_reg};
        end else if (hit_stat) begin
            io_word = stat_word;
        end else if (hit_data && do_pop) begin
            io_word = {24'd0, key_mem[rd_ptr_reg]};
        end else if (hit_tone) begin
            io_word = 32'(tone_reg);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            led_reg      <= '0;
            tone_reg     <= '0;
            key_irq_reg  <= 1'b0;
            sel_q_reg    <= SEL_RAM;
            io_rdata_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            sw_meta_reg <= SW;
            sw_sync_reg <= sw_meta_reg;

            if (wren && hit_led) begin
                led_reg <= data[15:0];
            end
            if (wren && hit_tone) begin
                tone_reg <= data[TONE_W-1:0];
            end

            sel_q_reg    <= is_ram ? SEL_RAM : SEL_IO;
            io_rdata_reg <= io_word;

            // Pointer arithmetic relies on KEY_DEPTH being a power of two.
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            key_irq_reg  <= (count_next != '0);
        end
    end

    assign q_dmem  = (sel_q_reg == SEL_RAM) ? ram_dataOut : io_rdata_reg;
    assign LED     = led_reg;
    assign tone    = tone_reg;
    assign key_irq = key_irq_reg;

endmodule
